rambus_arbiter: RTL and testbench
=================================

Name: rambus_arbiter

Overview:
- Shares the single rambus between two requesters: port 0 (instruction fetch) and port 1 (data, driven from the processor's RAM interface).
- Arbitrates, captures the winning request, drives the bus request handshake and routes the response back to its owner.
- Keeps one outstanding transaction at a time, with a response watchdog.

Parameters:
- AW, 32, address width
- DW, 32, data width; wstrb width is DW/8
- RSP_TIMEOUT, 255, cycles to wait for mem_rvalid before an error response; must be ≥1

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous active-high
- s0_req / s1_req  in  1  request; held with stable payload until the matching gnt
- s0_we / s1_we  in  1  1 = write, 0 = read
- s0_addr / s1_addr  in  AW  byte address, passed through unmodified
- s0_wstrb / s1_wstrb  in  DW/8  byte strobes
- s0_wdata / s1_wdata  in  DW  write data, already lane-shifted
- s0_gnt / s1_gnt  out  1  one-cycle pulse: payload captured
- s0_rvalid / s1_rvalid  out  1  one-cycle response pulse; for writes it is an ack
- s0_rdata / s1_rdata  out  DW  read data, valid with rvalid
- s0_err / s1_err  out  1  timeout error, valid with rvalid
- mem_req  out  1  bus request
- mem_we  out  1  bus write enable
- mem_addr  out  AW  bus address
- mem_wstrb  out  DW/8  bus byte strobes
- mem_wdata  out  DW  bus write data
- mem_gnt  in  1  bus accepted the request this cycle
- mem_rvalid  in  1  bus response valid
- mem_rdata  in  DW  bus read data

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous, active-high.
- Reset values: state=IDLE, owner=0, timeout counter=0, last-winner=1. All mem_* and sN_* outputs are 0.
- IDLE:
  - If any sN_req is high, pick a winner. Assert its sN_gnt combinationally in the same cycle.
  - Register {we, addr, wstrb, wdata} and owner, then go to REQ.
  - The loser sees no gnt and keeps its req high.
- REQ: mem_req=1 with the registered payload. Stay in REQ until mem_gnt; on mem_gnt go to WAIT and clear the counter.
- WAIT:
  - Counter increments every cycle.
  - If mem_rvalid: owner's sN_rvalid=1, sN_rdata=mem_rdata (combinational pass-through), sN_err=0; go to IDLE.
  - Otherwise, if counter==RSP_TIMEOUT-1: owner's sN_rvalid=1, sN_err=1, sN_rdata=0; go to IDLE.
  - If mem_rvalid and timeout coincide, the real response wins and err=0.
- Non-owner outputs: the non-owner's rvalid, err and rdata stay 0 at all times.
- Stray responses: mem_rvalid in IDLE or REQ is ignored, including late responses after a timeout.
- Latency: minimum is req at cycle 0 (gnt at 0), mem_req at 1 with mem_gnt at 1, rvalid at 2, next arbitration at 3.
- Fixed priority (default, macro off):
  - s1 (data) beats s0 (fetch).
  - A permanently asserted s1_req can starve s0. This is accepted.
- mem_* outputs are driven only in REQ: mem_we, mem_addr, mem_wstrb and mem_wdata are 0 outside REQ.
- Reset mid-operation:
  - The transaction is abandoned; no rvalid is issued to the owner.
  - The bus may still deliver a response, which is ignored under the stray-response rule.

Optional Feature:
- Macro RAMBUS_ARB_RR_EN.
- Defined: round-robin.
  - With both requesting in IDLE, the port that is not last-winner wins.
  - last-winner updates on every gnt.
  - A lone requester always wins.
- Undefined: fixed priority s1 > s0, and the last-winner register is not built.

Decomposition:
- typepkg additions:
  - arb_state_t enum {ARB_IDLE, ARB_REQ, ARB_WAIT}
  - mem_req_t packed struct {we, addr, wstrb, wdata}, used for the capture register
- Sub-module ramarb_pick: combinational 2-way picker.
  - Inputs: req[1:0], last.
  - Output: winner.
  - Contains the fixed/round-robin selection under RAMBUS_ARB_RR_EN.

Test Plan:
- Single read: s0_req, addr=0x100; bus gnt at once, rvalid 1 cycle later, rdata=0xDEADBEEF → s0_gnt at cycle 0, mem_req at cycle 1, s0_rvalid with 0xDEADBEEF at cycle 2, s1 outputs 0.
- Contention: s0 and s1 request together, s1 is a write of 0x000000AB with wstrb=0001 to 0x203.
  - Macro off: s1 served first, s0 served second.
  - Macro on with last-winner=1: s0 served first, s1 second.
- Bus backpressure: mem_gnt held low 5 cycles → mem_req and payload stable for 5 cycles; the loser gets no gnt meanwhile.
- Timeout with RSP_TIMEOUT=4: no mem_rvalid → owner rvalid=1, err=1, rdata=0 at the 4th WAIT cycle. A mem_rvalid arriving later in IDLE is ignored.
- Reset in WAIT: rst asserted 1 cycle → state IDLE, no rvalid to the owner; a following request is served normally.
- Starvation check, macro on: s1_req held high for 10 transactions alongside s0_req → grants alternate s1/s0.

Source files
------------

// File: rtl/rambus_arbiter_pkg.sv
// Shared types for the two-port rambus arbiter: FSM states and the captured bus request.
// The capture struct is sized by RAMARB_AW/RAMARB_DW, which must match the top's AW/DW.
package rambus_arbiter_pkg;

    localparam int RAMARB_AW = 32;
    localparam int RAMARB_DW = 32;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_WAIT
    } arb_state_t;

    typedef struct packed {
        logic                     we;
        logic [RAMARB_AW-1:0]     addr;
        logic [RAMARB_DW/8-1:0]   wstrb;
        logic [RAMARB_DW-1:0]     wdata;
    } mem_req_t;

endpackage

// File: rtl/ramarb_pick.sv
// Purpose: combinational 2-way winner select; fixed s1>s0, or round-robin with RAMBUS_ARB_RR_EN.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller only samples winner when some req is high.
module ramarb_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner
);

`ifdef RAMBUS_ARB_RR_EN
    // Only a genuine tie consults history; a lone requester always wins.
    always_comb begin
        winner = req[1];
        if (req == 2'b11) begin
            winner = ~last;
        end
    end
`else
    logic unused_last;
    assign unused_last = last;
    assign winner      = req[1];
`endif

endmodule

// File: rtl/rambus_arbiter.sv
// Purpose: shares one rambus between fetch (s0) and data (s1); RAMBUS_ARB_RR_EN selects round-robin.
// Latency: gnt same cycle as req, mem_req next cycle, rvalid the cycle after mem_gnt at the earliest.
// Backpressure: one outstanding transaction; losers hold req, mem_req holds until mem_gnt, watchdog ends WAIT.
module rambus_arbiter
    import rambus_arbiter_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int RSP_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            s0_req,
    input  logic            s0_we,
    input  logic [AW-1:0]   s0_addr,
    input  logic [DW/8-1:0] s0_wstrb,
    input  logic [DW-1:0]   s0_wdata,
    output logic            s0_gnt,
    output logic            s0_rvalid,
    output logic [DW-1:0]   s0_rdata,
    output logic            s0_err,

    input  logic            s1_req,
    input  logic            s1_we,
    input  logic [AW-1:0]   s1_addr,
    input  logic [DW/8-1:0] s1_wstrb,
    input  logic [DW-1:0]   s1_wdata,
    output logic            s1_gnt,
    output logic            s1_rvalid,
    output logic [DW-1:0]   s1_rdata,
    output logic            s1_err,

    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW/8-1:0] mem_wstrb,
    output logic [DW-1:0]   mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata
);

    localparam int CW = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;

    arb_state_t    state_q, state_d;
    mem_req_t      pay_q, pay_d;
    logic          owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [1:0]    req_vec;
    logic          winner;
    logic          last_w;
    logic          grant;
    logic          rsp_vld;
    logic          rsp_err;
    logic          in_req;

    assign req_vec = {s1_req, s0_req};

    ramarb_pick u_pick (
        .req    (req_vec),
        .last   (last_w),
        .winner (winner)
    );

`ifdef RAMBUS_ARB_RR_EN
    logic last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (grant) begin
            last_q <= winner;
        end
    end

    assign last_w = last_q;
`else
    assign last_w = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        pay_d   = pay_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        grant   = 1'b0;
        rsp_vld = 1'b0;
        rsp_err = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (|req_vec) begin
                    grant   = 1'b1;
                    owner_d = winner;
                    state_d = ARB_REQ;
                    if (winner) begin
                        pay_d.we    = s1_we;
                        pay_d.addr  = s1_addr;
                        pay_d.wstrb = s1_wstrb;
                        pay_d.wdata = s1_wdata;
                    end else begin
                        pay_d.we    = s0_we;
                        pay_d.addr  = s0_addr;
                        pay_d.wstrb = s0_wstrb;
                        pay_d.wdata = s0_wdata;
                    end
                end
            end
            ARB_REQ: begin
                if (mem_gnt) begin
                    state_d = ARB_WAIT;
                    cnt_d   = '0;
                end
            end
            ARB_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                // A real response beats a coincident watchdog expiry.
                if (mem_rvalid) begin
                    rsp_vld = 1'b1;
                    state_d = ARB_IDLE;
                end else if (cnt_q == CW'(RSP_TIMEOUT - 1)) begin
                    rsp_vld = 1'b1;
                    rsp_err = 1'b1;
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            pay_q   <= '0;
            owner_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pay_q   <= pay_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are masked during reset so an abandoned transaction never completes.
    assign s0_gnt    = grant & ~winner & ~rst;
    assign s1_gnt    = grant &  winner & ~rst;

    assign s0_rvalid = rsp_vld & ~owner_q & ~rst;
    assign s1_rvalid = rsp_vld &  owner_q & ~rst;
    assign s0_err    = rsp_err & ~owner_q & ~rst;
    assign s1_err    = rsp_err &  owner_q & ~rst;
    assign s0_rdata  = (s0_rvalid && !rsp_err) ? mem_rdata : '0;
    assign s1_rdata  = (s1_rvalid && !rsp_err) ? mem_rdata : '0;

    assign in_req    = (state_q == ARB_REQ) && !rst;
    assign mem_req   = in_req;
    assign mem_we    = in_req & pay_q.we;
    assign mem_addr  = in_req ? pay_q.addr  : '0;
    assign mem_wstrb = in_req ? pay_q.wstrb : '0;
    assign mem_wdata = in_req ? pay_q.wdata : '0;

endmodule

// File: tb/tb_rambus_arbiter.sv
// Directed bench for rambus_arbiter with RSP_TIMEOUT=4; expectations follow RAMBUS_ARB_RR_EN when defined.
module tb_rambus_arbiter;

    logic        clk;
    logic        rst;
    logic        s0_req, s0_we, s0_gnt, s0_rvalid, s0_err;
    logic [31:0] s0_addr, s0_wdata, s0_rdata;
    logic [3:0]  s0_wstrb;
    logic        s1_req, s1_we, s1_gnt, s1_rvalid, s1_err;
    logic [31:0] s1_addr, s1_wdata, s1_rdata;
    logic [3:0]  s1_wstrb;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int n_chk  = 0;
    int n_fail = 0;

    rambus_arbiter #(.AW(32), .DW(32), .RSP_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .s0_req(s0_req), .s0_we(s0_we), .s0_addr(s0_addr), .s0_wstrb(s0_wstrb), .s0_wdata(s0_wdata),
        .s0_gnt(s0_gnt), .s0_rvalid(s0_rvalid), .s0_rdata(s0_rdata), .s0_err(s0_err),
        .s1_req(s1_req), .s1_we(s1_we), .s1_addr(s1_addr), .s1_wstrb(s1_wstrb), .s1_wdata(s1_wdata),
        .s1_gnt(s1_gnt), .s1_rvalid(s1_rvalid), .s1_rdata(s1_rdata), .s1_err(s1_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "bench watchdog expired");
    end

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_s0(input logic we, input logic [31:0] addr, input logic [3:0] strb,
                          input logic [31:0] wd);
        s0_req = 1'b1; s0_we = we; s0_addr = addr; s0_wstrb = strb; s0_wdata = wd;
    endtask

    task automatic set_s1(input logic we, input logic [31:0] addr, input logic [3:0] strb,
                          input logic [31:0] wd);
        s1_req = 1'b1; s1_we = we; s1_addr = addr; s1_wstrb = strb; s1_wdata = wd;
    endtask

    // Called in an IDLE cycle with requests already driven; runs one zero-wait transaction for port p.
    task automatic xact(input int p, input logic we, input logic [31:0] addr, input logic [3:0] strb,
                        input logic [31:0] wd, input logic [31:0] rd);
        #1;
        chk_eq("gnt_s0", s0_gnt, p == 0);
        chk_eq("gnt_s1", s1_gnt, p == 1);
        chk_eq("idle_mem_req", mem_req, 0);
        step();
        if (p == 0) s0_req = 1'b0; else s1_req = 1'b0;
        mem_gnt = 1'b1;
        #1;
        chk_eq("req_mem_req", mem_req, 1);
        chk_eq("req_mem_we", mem_we, we);
        chk_eq("req_mem_addr", mem_addr, addr);
        chk_eq("req_mem_wstrb", mem_wstrb, strb);
        chk_eq("req_mem_wdata", mem_wdata, wd);
        chk_eq("req_no_gnt", {s0_gnt, s1_gnt}, 0);
        step();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rd;
        #1;
        chk_eq("rsp_s0_rvalid", s0_rvalid, p == 0);
        chk_eq("rsp_s1_rvalid", s1_rvalid, p == 1);
        chk_eq("rsp_s0_rdata", s0_rdata, (p == 0) ? rd : 32'h0);
        chk_eq("rsp_s1_rdata", s1_rdata, (p == 1) ? rd : 32'h0);
        chk_eq("rsp_err", {s0_err, s1_err}, 0);
        chk_eq("rsp_mem_req", mem_req, 0);
        step();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
    endtask

    initial begin
        int first;
        int exp_p;
        rst = 1'b1;
        s0_req = 0; s0_we = 0; s0_addr = 0; s0_wstrb = 0; s0_wdata = 0;
        s1_req = 0; s1_we = 0; s1_addr = 0; s1_wstrb = 0; s1_wdata = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;

        // Reset: outputs quiet even with a request present.
        step();
        s0_req = 1'b1;
        #1;
        chk_eq("rst_gnt", {s0_gnt, s1_gnt}, 0);
        chk_eq("rst_mem_req", mem_req, 0);
        step();
        rst = 1'b0; s0_req = 1'b0;
        #1;
        chk_eq("post_rst_outs", {s0_gnt, s1_gnt, s0_rvalid, s1_rvalid, s0_err, s1_err, mem_req, mem_we}, 0);
        chk_eq("post_rst_bus", {mem_addr, mem_wdata, mem_wstrb}, 0);

        // Single read on s0.
        set_s0(1'b0, 32'h100, 4'h0, 32'h0);
        xact(0, 1'b0, 32'h100, 4'h0, 32'h0, 32'hDEADBEEF);
        #1;
        chk_eq("after_read_idle", {mem_req, s0_rvalid, s1_rvalid}, 0);

        // Contention from a fresh reset so last-winner is 1.
        rst = 1'b1;
        step();
        rst = 1'b0;
`ifdef RAMBUS_ARB_RR_EN
        first = 0;
`else
        first = 1;
`endif
        set_s0(1'b0, 32'h300, 4'h0, 32'h0);
        set_s1(1'b1, 32'h203, 4'h1, 32'h000000AB);
        if (first == 1) begin
            xact(1, 1'b1, 32'h203, 4'h1, 32'h000000AB, 32'h12345678);
            xact(0, 1'b0, 32'h300, 4'h0, 32'h0, 32'h0BADF00D);
        end else begin
            xact(0, 1'b0, 32'h300, 4'h0, 32'h0, 32'h0BADF00D);
            xact(1, 1'b1, 32'h203, 4'h1, 32'h000000AB, 32'h12345678);
        end

        // Bus backpressure: mem_gnt low for 5 cycles, loser must wait.
        set_s0(1'b0, 32'h400, 4'h0, 32'h0);
        #1;
        chk_eq("bp_gnt_s0", s0_gnt, 1);
        step();
        s0_req = 1'b0;
        set_s1(1'b1, 32'h500, 4'hF, 32'h55AA55AA);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk_eq("bp_mem_req", mem_req, 1);
            chk_eq("bp_mem_addr", mem_addr, 32'h400);
            chk_eq("bp_loser_gnt", s1_gnt, 0);
            step();
        end
        mem_gnt = 1'b1;
        #1;
        chk_eq("bp_accept_req", mem_req, 1);
        step();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00004444;
        #1;
        chk_eq("bp_s0_rvalid", s0_rvalid, 1);
        chk_eq("bp_s0_rdata", s0_rdata, 32'h00004444);
        step();
        mem_rvalid = 1'b0;
        xact(1, 1'b1, 32'h500, 4'hF, 32'h55AA55AA, 32'h0);

        // Timeout: no response for 4 WAIT cycles, then a stray late response.
        set_s0(1'b0, 32'h600, 4'h0, 32'h0);
        #1;
        chk_eq("to_gnt", s0_gnt, 1);
        step();
        s0_req = 1'b0; mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0; mem_rdata = 32'hCAFEF00D;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_eq("to_wait_rvalid", s0_rvalid, 0);
            step();
        end
        #1;
        chk_eq("to_rvalid", s0_rvalid, 1);
        chk_eq("to_err", s0_err, 1);
        chk_eq("to_rdata", s0_rdata, 32'h0);
        chk_eq("to_s1_quiet", {s1_rvalid, s1_err, s1_rdata}, 0);
        step();
        mem_rvalid = 1'b1;
        #1;
        chk_eq("stray_rvalid", {s0_rvalid, s1_rvalid, s0_err}, 0);
        chk_eq("stray_mem_req", mem_req, 0);
        step();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;

        // Response coinciding with the timeout cycle wins with err=0.
        set_s1(1'b0, 32'h680, 4'h0, 32'h0);
        step();
        s1_req = 1'b0; mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        step(); step(); step();
        mem_rvalid = 1'b1; mem_rdata = 32'h7777AAAA;
        #1;
        chk_eq("coinc_rvalid", s1_rvalid, 1);
        chk_eq("coinc_err", s1_err, 0);
        chk_eq("coinc_rdata", s1_rdata, 32'h7777AAAA);
        step();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;

        // Reset while in WAIT: no rvalid, then normal service.
        set_s1(1'b0, 32'h700, 4'h0, 32'h0);
        step();
        s1_req = 1'b0; mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0; rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h11112222;
        #1;
        chk_eq("rstw_rvalid", {s0_rvalid, s1_rvalid}, 0);
        step();
        rst = 1'b0;
        #1;
        chk_eq("rstw_late_rvalid", {s0_rvalid, s1_rvalid}, 0);
        chk_eq("rstw_mem_req", mem_req, 0);
        step();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        set_s0(1'b0, 32'h740, 4'h0, 32'h0);
        xact(0, 1'b0, 32'h740, 4'h0, 32'h0, 32'h33334444);

        // s1 held high alongside s0 for 10 transactions (last winner is s0 here).
        for (int i = 0; i < 10; i++) begin
            set_s0(1'b0, 32'h800, 4'h0, 32'h0);
            set_s1(1'b1, 32'h900, 4'h3, 32'(i));
`ifdef RAMBUS_ARB_RR_EN
            exp_p = (i % 2 == 0) ? 1 : 0;
`else
            exp_p = 1;
`endif
            if (exp_p == 1)
                xact(1, 1'b1, 32'h900, 4'h3, 32'(i), 32'h0);
            else
                xact(0, 1'b0, 32'h800, 4'h0, 32'h0, 32'h00000800 + 32'(i));
        end
        s0_req = 1'b0; s1_req = 1'b0;
        #1;
        chk_eq("end_idle", {mem_req, s0_gnt, s1_gnt}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
